// File: rtl/seq_pattern_tx_if.sv
// Bus between a pattern requester and seq_pattern_tx: start/config in, serial stream and status out.
interface seq_pattern_tx_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int REP_W   = 4,
    parameter int GAP_W   = 4
);
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [REP_W-1:0]   repeats;
    logic [GAP_W-1:0]   gap;
    logic               abort;
    logic               xout;
    logic               bit_valid;
    logic               frame_start;
    logic               busy;
    logic               done;

    modport master (
        output start, pattern, len, repeats, gap, abort,
        input  xout, bit_valid, frame_start, busy, done
    );

    modport slave (
        input  start, pattern, len, repeats, gap, abort,
        output xout, bit_valid, frame_start, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial test-pattern transmitter: shifts a latched pattern MSB-first on xout,
// repeating it with optional idle gaps, under a start/busy/done handshake.
module seq_pattern_tx #(
    parameter int MAX_LEN  = 8,
    parameter int LEN_W    = 4,
    parameter int REP_W    = 4,
    parameter int GAP_W    = 4,
    parameter bit IDLE_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    seq_pattern_tx_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t             state_q, state_n;
    logic [MAX_LEN-1:0] pat_q, pat_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [LEN_W-1:0]   idx_q, idx_n;
    logic [REP_W-1:0]   frm_q, frm_n;
    logic [GAP_W-1:0]   gapv_q, gapv_n;
    logic [GAP_W-1:0]   gcnt_q, gcnt_n;
    logic               xout_q, xout_n;
    logic               bv_q, bv_n;
    logic               fs_q, fs_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [LEN_W-1:0]   len_in;

    function automatic logic pick(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < MAX_LEN; k++)
            if (LEN_W'(k) == i) b = p[k];
        return b;
    endfunction

    always_comb len_in = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;

    // Outputs are computed for the cycle being entered and registered, so
    // the first bit appears the cycle right after start is accepted.
    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        len_n   = len_q;
        idx_n   = idx_q;
        frm_n   = frm_q;
        gapv_n  = gapv_q;
        gcnt_n  = gcnt_q;
        xout_n  = IDLE_VAL;
        bv_n    = 1'b0;
        fs_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && bus.len != '0) begin
                    state_n = SHIFT;
                    pat_n   = bus.pattern;
                    len_n   = len_in;
                    frm_n   = bus.repeats;
                    gapv_n  = bus.gap;
                    idx_n   = len_in - 1'b1;
                    xout_n  = pick(bus.pattern, len_in - 1'b1);
                    bv_n    = 1'b1;
                    fs_n    = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            SHIFT: begin
                busy_n = 1'b1;
                if (idx_q != '0) begin
                    idx_n  = idx_q - 1'b1;
                    xout_n = pick(pat_q, idx_q - 1'b1);
                    bv_n   = 1'b1;
                end else if (frm_q == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    frm_n = frm_q - 1'b1;
                    if (gapv_q != '0) begin
                        state_n = GAP;
                        gcnt_n  = gapv_q;
                    end else begin
                        idx_n  = len_q - 1'b1;
                        xout_n = pick(pat_q, len_q - 1'b1);
                        bv_n   = 1'b1;
                        fs_n   = 1'b1;
                    end
                end
            end
            GAP: begin
                busy_n = 1'b1;
                // gcnt holds the gap cycles remaining including this one
                if (gcnt_q == GAP_W'(1)) begin
                    state_n = SHIFT;
                    idx_n   = len_q - 1'b1;
                    xout_n  = pick(pat_q, len_q - 1'b1);
                    bv_n    = 1'b1;
                    fs_n    = 1'b1;
                end else begin
                    gcnt_n = gcnt_q - 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state_q != IDLE && bus.abort) begin
            state_n = IDLE;
            xout_n  = IDLE_VAL;
            bv_n    = 1'b0;
            fs_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            gapv_q  <= '0;
            gcnt_q  <= '0;
            xout_q  <= IDLE_VAL;
            bv_q    <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pat_q   <= pat_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
            frm_q   <= frm_n;
            gapv_q  <= gapv_n;
            gcnt_q  <= gcnt_n;
            xout_q  <= xout_n;
            bv_q    <= bv_n;
            fs_q    <= fs_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.xout        = xout_q;
    assign bus.bit_valid   = bv_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: drives on negedge, samples on negedge,
// outputs packed as {xout, bit_valid, frame_start, busy, done}.
module tb_seq_pattern_tx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_tx_if #(.MAX_LEN(8), .LEN_W(4), .REP_W(4), .GAP_W(4)) bus ();

    seq_pattern_tx #(.MAX_LEN(8), .LEN_W(4), .REP_W(4), .GAP_W(4), .IDLE_VAL(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    int          cap_n, cap_fs, cap_done;
    logic [63:0] cap_x, cap_v;

    function automatic logic [4:0] outs();
        return {bus.xout, bus.bit_valid, bus.frame_start, bus.busy, bus.done};
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.pattern = '0; bus.len = '0;
        bus.repeats = '0; bus.gap = '0; bus.abort = 1'b0;
    endtask

    // Call at a negedge; returns at the negedge of the first transmit cycle.
    task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [3:0] g);
        bus.pattern = p; bus.len = l; bus.repeats = r; bus.gap = g;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Records every busy cycle; returns at the negedge of the first non-busy cycle.
    task automatic capture();
        cap_n = 0; cap_fs = 0; cap_done = 0; cap_x = '0; cap_v = '0;
        for (int c = 0; c < 200; c++) begin
            if (!bus.busy) break;
            cap_x = {cap_x[62:0], bus.xout};
            cap_v = {cap_v[62:0], bus.bit_valid};
            cap_fs += int'(bus.frame_start);
            cap_done += int'(bus.done);
            cap_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.start = 1'b1; bus.len = 4'd3; bus.pattern = 8'b110;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 5'b00000) begin
            failures++; $display("FAIL reset_hold: got %b expected %b", outs(), 5'b00000);
        end
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== 5'b00000) begin
            failures++; $display("FAIL reset_release: got %b expected %b", outs(), 5'b00000);
        end
    endtask

    task automatic test_single();
        logic [4:0] exp [5];
        logic [2:0] hist;
        int         ycnt;
        exp = '{5'b11110, 5'b11010, 5'b01010, 5'b00011, 5'b00000};
        hist = '0; ycnt = 0;
        do_start(8'b110, 4'd3, 4'd0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (outs() !== exp[k]) begin
                failures++; $display("FAIL single_cycle%0d: got %b expected %b", k + 1, outs(), exp[k]);
            end
            if (bus.bit_valid) begin
                hist = {hist[1:0], bus.xout};
                if (hist == 3'b110) ycnt++;
            end
            @(negedge clk);
        end
        checks++;
        if (ycnt !== 1) begin
            failures++; $display("FAIL single_detect110: got %0d expected %0d", ycnt, 1);
        end
    endtask

    task automatic test_repeat_gap();
        do_start(8'b1011, 4'd4, 4'd2, 4'd2);
        capture();
        checks++;
        if (cap_n !== 17) begin
            failures++; $display("FAIL rep_busy_cycles: got %0d expected %0d", cap_n, 17);
        end
        checks++;
        if (cap_x[16:0] !== 17'b10110010110010110) begin
            failures++; $display("FAIL rep_xout: got %b expected %b", cap_x[16:0], 17'b10110010110010110);
        end
        checks++;
        if (cap_v[16:0] !== 17'b11110011110011110) begin
            failures++; $display("FAIL rep_valid: got %b expected %b", cap_v[16:0], 17'b11110011110011110);
        end
        checks++;
        if (cap_fs !== 3) begin
            failures++; $display("FAIL rep_frame_start: got %0d expected %0d", cap_fs, 3);
        end
        checks++;
        if (cap_done !== 1) begin
            failures++; $display("FAIL rep_done: got %0d expected %0d", cap_done, 1);
        end
    endtask

    task automatic test_ignored_start();
        logic [4:0] exp [6];
        exp = '{5'b11110, 5'b11010, 5'b01010, 5'b00011, 5'b00000, 5'b00000};
        do_start(8'b110, 4'd3, 4'd0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (outs() !== exp[k]) begin
                failures++; $display("FAIL ignstart_cycle%0d: got %b expected %b", k + 1, outs(), exp[k]);
            end
            // poke start mid-frame and in the DONE cycle with a different config
            if (k == 1 || k == 3) begin
                bus.start = 1'b1; bus.pattern = 8'hFF; bus.len = 4'd8;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.pattern = 8'hFF; bus.len = 4'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (outs() !== 5'b00000) begin
                failures++; $display("FAIL len0_cycle%0d: got %b expected %b", k + 1, outs(), 5'b00000);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clamp();
        do_start(8'hA5, 4'd12, 4'd0, 4'd0);
        capture();
        checks++;
        if (cap_n !== 9) begin
            failures++; $display("FAIL clamp_busy_cycles: got %0d expected %0d", cap_n, 9);
        end
        checks++;
        if (cap_x[8:0] !== 9'b101001010) begin
            failures++; $display("FAIL clamp_xout: got %b expected %b", cap_x[8:0], 9'b101001010);
        end
        checks++;
        if (cap_fs !== 1 || cap_done !== 1) begin
            failures++; $display("FAIL clamp_fs_done: got %0d/%0d expected 1/1", cap_fs, cap_done);
        end
    endtask

    task automatic test_abort();
        do_start(8'b110, 4'd3, 4'd0, 4'd0);
        checks++;
        if (outs() !== 5'b11110) begin
            failures++; $display("FAIL abort_bit1: got %b expected %b", outs(), 5'b11110);
        end
        @(negedge clk);
        checks++;
        if (outs() !== 5'b11010) begin
            failures++; $display("FAIL abort_bit2: got %b expected %b", outs(), 5'b11010);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (outs() !== 5'b00000) begin
            failures++; $display("FAIL abort_after: got %b expected %b", outs(), 5'b00000);
        end
        do_start(8'b110, 4'd3, 4'd0, 4'd0);
        capture();
        checks++;
        if (cap_n !== 4 || cap_x[3:0] !== 4'b1100 || cap_done !== 1) begin
            failures++; $display("FAIL abort_restart: got n=%0d x=%b done=%0d expected n=4 x=1100 done=1",
                                 cap_n, cap_x[3:0], cap_done);
        end
    endtask

    task automatic test_abort_idle();
        bus.abort = 1'b1;
        do_start(8'b101, 4'd3, 4'd0, 4'd0);
        bus.abort = 1'b0;
        capture();
        checks++;
        if (cap_n !== 4 || cap_x[3:0] !== 4'b1010 || cap_done !== 1) begin
            failures++; $display("FAIL abort_idle_start: got n=%0d x=%b done=%0d expected n=4 x=1010 done=1",
                                 cap_n, cap_x[3:0], cap_done);
        end
    endtask

    task automatic test_reset_gap();
        do_start(8'b1011, 4'd4, 4'd2, 4'd2);
        repeat (4) @(negedge clk);
        checks++;
        if (outs() !== 5'b00010) begin
            failures++; $display("FAIL rstgap_in_gap: got %b expected %b", outs(), 5'b00010);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (outs() !== 5'b00000) begin
            failures++; $display("FAIL rstgap_async: got %b expected %b", outs(), 5'b00000);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== 5'b00000) begin
            failures++; $display("FAIL rstgap_idle: got %b expected %b", outs(), 5'b00000);
        end
        do_start(8'b110, 4'd3, 4'd0, 4'd0);
        capture();
        checks++;
        if (cap_n !== 4 || cap_x[3:0] !== 4'b1100 || cap_fs !== 1 || cap_done !== 1) begin
            failures++; $display("FAIL rstgap_restart: got n=%0d x=%b fs=%0d done=%0d expected n=4 x=1100 fs=1 done=1",
                                 cap_n, cap_x[3:0], cap_fs, cap_done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_ignored_start();
        test_clamp();
        test_abort();
        test_abort_idle();
        test_reset_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
